// File: rtl/step_dir_rx_if.sv
// Step/dir receiver bus: asynchronous pin inputs, synchronous requests, position/status outputs.
// master drives the pins and requests, slave is the receiver.
interface step_dir_rx_if #(
    parameter int pos_w = 32
);
    logic                    nen;
    logic                    dir;
    logic                    step;
    logic                    zero_pos;
    logic                    clr_faults;
    logic signed [pos_w-1:0] position;
    logic                    step_pulse;
    logic [31:0]             step_period;
    logic                    moving;
    logic                    fault_overspeed;
    logic                    fault_dir_setup;
    logic                    fault_disabled;
    logic                    fault;

    modport master (
        output nen, dir, step, zero_pos, clr_faults,
        input  position, step_pulse, step_period, moving,
               fault_overspeed, fault_dir_setup, fault_disabled, fault
    );

    modport slave (
        input  nen, dir, step, zero_pos, clr_faults,
        output position, step_pulse, step_period, moving,
               fault_overspeed, fault_dir_setup, fault_disabled, fault
    );
endinterface

// File: rtl/step_dir_rx.sv
// Step/dir receiver: synchronizes pins and accumulates a signed position. It also tracks step timing and raises sticky faults.
// Latency: a step sampled at edge N updates registers at edge N+2. There is no backpressure; every step edge is evaluated.
module step_dir_rx #(
    parameter int clk_hz        = 25000000,
    parameter int max_step_hz   = 2000,
    parameter int dir_setup_cyc = 25,
    parameter int idle_cyc      = 250000,
    parameter int pos_w         = 32
) (
    input  logic         clk,
    input  logic         rst,
    step_dir_rx_if.slave bus
);
    localparam logic [31:0] idle_lim  = 32'(idle_cyc);
    localparam logic [31:0] min_per   = 32'(clk_hz / max_step_hz);
    localparam logic [31:0] setup_lim = 32'(dir_setup_cyc);

    logic [1:0]              nen_sync;
    logic [1:0]              dir_sync;
    logic [1:0]              step_sync;
    logic                    step_prev;
    logic                    dir_prev;
    logic [31:0]             period_cnt;
    logic [31:0]             dir_age;
    logic signed [pos_w-1:0] position;
    logic                    step_pulse;
    logic [31:0]             step_period;
    logic                    moving;
    logic                    fault_overspeed;
    logic                    fault_dir_setup;
    logic                    fault_disabled;

    logic                    step_evt;
    logic                    accept;
    logic [31:0]             elapsed;
    logic signed [pos_w-1:0] pos_base;
    logic signed [pos_w-1:0] pos_delta;

    assign step_evt  = step_sync[1] & ~step_prev;
    assign accept    = step_evt & ~nen_sync[1];
    // The counter was cleared on the previous event's edge, so it lags by one; elapsed includes the event cycle itself.
    assign elapsed   = (period_cnt >= idle_lim) ? idle_lim : period_cnt + 32'd1;
    assign pos_base  = bus.zero_pos ? '0 : position;
    assign pos_delta = dir_sync[1] ? pos_w'(1) : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nen_sync        <= 2'b11;
            dir_sync        <= 2'b00;
            step_sync       <= 2'b00;
            step_prev       <= 1'b0;
            dir_prev        <= 1'b0;
            period_cnt      <= idle_lim;
            dir_age         <= setup_lim;
            position        <= '0;
            step_pulse      <= 1'b0;
            step_period     <= '0;
            moving          <= 1'b0;
            fault_overspeed <= 1'b0;
            fault_dir_setup <= 1'b0;
            fault_disabled  <= 1'b0;
        end else begin
            nen_sync  <= {nen_sync[0], bus.nen};
            dir_sync  <= {dir_sync[0], bus.dir};
            step_sync <= {step_sync[0], bus.step};
            step_prev <= step_sync[1];
            dir_prev  <= dir_sync[1];

            if (step_evt) begin
                period_cnt  <= '0;
                step_period <= elapsed;
            end else if (period_cnt < idle_lim) begin
                period_cnt <= period_cnt + 32'd1;
            end
            moving <= (period_cnt < idle_lim);

            if (dir_sync[1] != dir_prev)
                dir_age <= '0;
            else if (dir_age < setup_lim)
                dir_age <= dir_age + 32'd1;

            position   <= accept ? pos_base + pos_delta : pos_base;
            step_pulse <= accept;

            // A fault raised in the same cycle as clr_faults survives the clear.
            fault_overspeed <= (fault_overspeed & ~bus.clr_faults) | (step_evt & (elapsed < min_per));
            fault_dir_setup <= (fault_dir_setup & ~bus.clr_faults) | (step_evt & (dir_age < setup_lim));
            fault_disabled  <= (fault_disabled  & ~bus.clr_faults) | (step_evt & nen_sync[1]);
        end
    end

    assign bus.position        = position;
    assign bus.step_pulse      = step_pulse;
    assign bus.step_period     = step_period;
    assign bus.moving          = moving;
    assign bus.fault_overspeed = fault_overspeed;
    assign bus.fault_dir_setup = fault_dir_setup;
    assign bus.fault_disabled  = fault_disabled;
    assign bus.fault           = fault_overspeed | fault_dir_setup | fault_disabled;
endmodule

// File: tb/tb_step_dir_rx.sv
// Scoreboard bench for step_dir_rx: each accepted step pushes its expected position, period and pulse cycle.
// The pulse monitor pops those expectations and compares them against the DUT.
module tb_step_dir_rx;
    localparam int IDLE = 2000;

    logic clk;
    logic rst;
    step_dir_rx_if #(.pos_w(8)) bus ();

    step_dir_rx #(
        .clk_hz(200000), .max_step_hz(2000), .dir_setup_cyc(25),
        .idle_cyc(IDLE), .pos_w(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        longint pos;
        longint period;
        longint cyc;
    } sb_t;

    sb_t                sb[$];
    longint             cyc;
    longint             last_k;
    logic signed [7:0]  exp_pos;
    int                 n_checks;
    int                 n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!rst && bus.step_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_pos", longint'(bus.position), e.pos);
                chk("pulse_period", longint'(bus.step_period), e.period);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One step rise, held for 4 cycles; the next call starts 'gap' cycles later.
    task automatic do_step(input int gap, input bit with_zero);
        longint k;
        longint el;
        sb_t    e;
        @(negedge clk);
        bus.step = 1'b1;
        k = cyc;
        el = k - last_k;
        if (el > IDLE) el = IDLE;
        last_k = k;
        if (!bus.nen) begin
            exp_pos  = (with_zero ? 8'sd0 : exp_pos) + (bus.dir ? 8'sd1 : -8'sd1);
            e.pos    = longint'(exp_pos);
            e.period = el;
            e.cyc    = k + 3;
            sb.push_back(e);
        end
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            bus.zero_pos = with_zero && (i == 2);
            if (i == 4) bus.step = 1'b0;
        end
        bus.zero_pos = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        bus.clr_faults = 1'b1;
        @(negedge clk);
        bus.clr_faults = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_k   = -100000;
        exp_pos  = 8'sd0;
        rst            = 1'b1;
        bus.nen        = 1'b0;
        bus.dir        = 1'b1;
        bus.step       = 1'b0;
        bus.zero_pos   = 1'b0;
        bus.clr_faults = 1'b0;
        wait_cyc(3);
        chk("rst_position", longint'(bus.position), 0);
        chk("rst_step_pulse", bus.step_pulse, 0);
        chk("rst_step_period", bus.step_period, 0);
        chk("rst_moving", bus.moving, 0);
        chk("rst_fault", bus.fault, 0);
        rst = 1'b0;
        wait_cyc(40);

        // forward steps at 200-cycle spacing
        for (int i = 0; i < 5; i++) do_step(200, 1'b0);
        chk("fwd_position", longint'(bus.position), 5);
        chk("fwd_step_period", bus.step_period, 200);
        chk("fwd_fault", bus.fault, 0);
        chk("fwd_moving", bus.moving, 1);
        wait_cyc(IDLE + 10);
        chk("idle_moving", bus.moving, 0);

        // reverse steps, standalone zero, then zero coincident with a step
        bus.dir = 1'b0;
        wait_cyc(40);
        @(negedge clk) bus.zero_pos = 1'b1;
        @(negedge clk) bus.zero_pos = 1'b0;
        exp_pos = 8'sd0;
        chk("zero_position", longint'(bus.position), 0);
        for (int i = 0; i < 3; i++) do_step(200, 1'b0);
        chk("rev_position", longint'(bus.position), -3);
        do_step(200, 1'b1);
        chk("zero_step_position", longint'(bus.position), -1);
        chk("rev_fault", bus.fault, 0);

        // overspeed: two steps 80 cycles apart, below the 100-cycle minimum
        bus.dir = 1'b1;
        wait_cyc(40);
        do_step(80, 1'b0);
        do_step(200, 1'b0);
        chk("ovs_position", longint'(bus.position), 1);
        chk("ovs_flag", bus.fault_overspeed, 1);
        chk("ovs_fault", bus.fault, 1);
        chk("ovs_dir_setup", bus.fault_dir_setup, 0);
        pulse_clr();
        chk("ovs_cleared", bus.fault, 0);

        // dir changes 10 cycles before the step rise
        bus.dir = 1'b0;
        wait_cyc(9);
        do_step(200, 1'b0);
        chk("dsu_position", longint'(bus.position), 0);
        chk("dsu_flag", bus.fault_dir_setup, 1);
        chk("dsu_overspeed", bus.fault_overspeed, 0);
        pulse_clr();
        chk("dsu_cleared", bus.fault, 0);

        // disabled driver: steps rejected
        bus.nen = 1'b1;
        wait_cyc(30);
        do_step(200, 1'b0);
        do_step(200, 1'b0);
        chk("dis_position", longint'(bus.position), 0);
        chk("dis_flag", bus.fault_disabled, 1);
        chk("dis_overspeed", bus.fault_overspeed, 0);
        pulse_clr();
        chk("dis_cleared", bus.fault, 0);
        bus.nen = 1'b0;
        bus.dir = 1'b1;
        wait_cyc(40);

        // wrap: 127 forward steps reach max, one more gives min
        for (int i = 0; i < 127; i++) do_step(110, 1'b0);
        chk("wrap_max", longint'(bus.position), 127);
        do_step(110, 1'b0);
        chk("wrap_min", longint'(bus.position), -128);
        chk("wrap_fault", bus.fault, 0);
        wait_cyc(IDLE - 150);
        chk("idle_edge_moving", bus.moving, 1);
        wait_cyc(200);
        chk("idle_end_moving", bus.moving, 0);

        // reset while a step is in the synchronizer
        @(negedge clk) bus.step = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_position", longint'(bus.position), 0);
        chk("midrst_pulse", bus.step_pulse, 0);
        wait_cyc(2);
        bus.step = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        exp_pos = 8'sd0;
        last_k  = -100000;
        wait_cyc(20);
        chk("midrst_after", longint'(bus.position), 0);
        chk("midrst_period", bus.step_period, 0);

        chk("pending_pulses", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
